// File: rtl/ni_multichannel_pkg.sv
// Shared types for the multichannel NI register block: DMNI payload types, the
// register map and the offsets of the IRQ status bits that sit above the receive bits.
package ni_multichannel_pkg;

   typedef enum logic {
      HERMES_SEND    = 1'b0,
      HERMES_RECEIVE = 1'b1
   } hermes_op_t;

   typedef struct packed {
      logic [7:0]  service;
      logic [7:0]  ksvc;
      logic [15:0] target;
      logic [15:0] producer;
      logic [31:0] payload;
   } brlite_out_t;

   typedef struct packed {
      logic [7:0]  service;
      logic [7:0]  ksvc;
      logic [15:0] producer;
      logic [31:0] payload;
   } brlite_svc_t;

   typedef brlite_out_t br_tx_entry_t;

   typedef enum logic [5:0] {
      NI_ADDRESS        = 6'd0,
      NI_CH_SEL         = 6'd1,
      NI_H_START        = 6'd2,
      NI_H_OP           = 6'd3,
      NI_H_SIZE         = 6'd4,
      NI_H_ADDR         = 6'd5,
      NI_BR_SERVICE     = 6'd8,
      NI_BR_KSVC        = 6'd9,
      NI_BR_TARGET      = 6'd10,
      NI_BR_PRODUCER    = 6'd11,
      NI_BR_PAYLOAD     = 6'd12,
      NI_BR_PUSH        = 6'd13,
      NI_BR_TX_LEVEL    = 6'd14,
      NI_BR_SVC_POP     = 6'd15,
      NI_BR_SVC_HDR     = 6'd16,
      NI_BR_SVC_PAYLOAD = 6'd17,
      NI_PENDING_SVC    = 6'd18,
      NI_IRQ_STATUS     = 6'd19,
      NI_IRQ_MASK       = 6'd20,
      NI_BR_OVF_CNT     = 6'd21
   } ni_reg_t;

   // Offsets above the N per-channel receive bits
   localparam int unsigned IRQ_OFS_BR_SVC     = 0;
   localparam int unsigned IRQ_OFS_PENDING    = 1;
   localparam int unsigned IRQ_OFS_BR_OVF     = 2;
   localparam int unsigned IRQ_OFS_TX_DRAINED = 3;
   localparam int unsigned IRQ_OFS_CH_ERR     = 4;
   localparam int unsigned IRQ_EXTRA_BITS     = 5;

endpackage

// File: rtl/ni_br_tx_fifo.sv
// BrLite transmit queue: power-of-two circular buffer with simultaneous push/pop
// accepted when full; head is the oldest entry.
module ni_br_tx_fifo
   import ni_multichannel_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = br_tx_entry_t
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  T                           i_data,
   output T                           o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   T               r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           w_do_push;
   logic           w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot the push needs
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ni_multichannel.sv
// CPU-facing NI register block: N Hermes DMA channels, BrLite TX queue, masked IRQ.
// Optional NI_BR_OVF_CNT_EN adds a saturating dropped-push counter at NI_BR_OVF_CNT.
module ni_multichannel
   import ni_multichannel_pkg::*;
#(
   parameter int unsigned N_HERMES_CH      = 2,
   parameter int unsigned HERMES_FLIT_SIZE = 32,
   parameter int unsigned BR_TX_DEPTH      = 4,
   parameter logic [15:0] ADDRESS          = 16'h0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        cfg_en_i,
   input  logic                        cfg_we_i,
   input  logic [5:0]                  cfg_addr_i,
   input  logic [31:0]                 cfg_data_i,
   output logic [31:0]                 cfg_data_o,
   output logic                        irq_o,
   input  logic [N_HERMES_CH-1:0]      hermes_send_active_i,
   input  logic [N_HERMES_CH-1:0]      hermes_receive_avail_i,
   output logic [N_HERMES_CH-1:0]      hermes_start_o,
   output logic [N_HERMES_CH-1:0]      hermes_operation_o,
   output logic [N_HERMES_CH*32-1:0]   hermes_size_o,
   output logic [N_HERMES_CH*32-1:0]   hermes_address_o,
   input  logic                        br_svc_rx_i,
   input  brlite_svc_t                 br_svc_data_i,
   output logic                        br_svc_ack_o,
   output logic                        br_req_o,
   input  logic                        br_ack_i,
   output brlite_out_t                 br_data_o
);

   localparam int unsigned N     = N_HERMES_CH;
   localparam int unsigned IRQ_W = N + IRQ_EXTRA_BITS;
   localparam int unsigned CNT_W = $clog2(BR_TX_DEPTH) + 1;

   ni_reg_t             w_addr;
   logic                w_wr;
   logic                w_rd;
   logic [N-1:0]        w_ch_onehot;
   logic                w_ch_busy;
   logic                w_wr_start;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [CNT_W-1:0]    w_count;
   br_tx_entry_t        w_head;
   logic                w_ovf_set;
   logic                w_drain_set;
   logic                w_err_set;
   logic                w_wr_irq;
   logic [IRQ_W-1:0]    w_status;
   logic [15:0]         w_ovf_cnt;
   logic [31:0]         w_rdata;

   logic [2:0]          r_ch_sel;
   logic [N-1:0]        r_start;
   logic [N-1:0]        r_op;
   logic [N-1:0][31:0]  r_size;
   logic [N-1:0][31:0]  r_addr;
   br_tx_entry_t        r_stage;
   logic                r_svc_ack;
   logic                r_pending;
   logic                r_ovf;
   logic                r_drained;
   logic                r_ch_err;
   logic [IRQ_W-1:0]    r_mask;
   logic [31:0]         r_rdata;

   assign w_addr = ni_reg_t'(cfg_addr_i);
   assign w_wr   = cfg_en_i && cfg_we_i;
   assign w_rd   = cfg_en_i && !cfg_we_i;

   // Channel select decode; an out-of-range select leaves the one-hot empty
   always_comb begin
      w_ch_onehot = '0;
      for (int c = 0; c < int'(N); c++) w_ch_onehot[c] = (r_ch_sel == 3'(c));
   end

   assign w_ch_busy  = |(w_ch_onehot & hermes_send_active_i);
   assign w_wr_start = w_wr && (w_addr == NI_H_START) && cfg_data_i[0];
   assign w_err_set  = w_wr_start && w_ch_busy;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ch_sel <= '0;
         r_start  <= '0;
         r_op     <= '0;
         r_size   <= '0;
         r_addr   <= '0;
      end else begin
         if (w_wr && (w_addr == NI_CH_SEL)) r_ch_sel <= cfg_data_i[2:0];
         r_start <= (w_wr_start && !w_ch_busy) ? w_ch_onehot : '0;
         for (int c = 0; c < int'(N); c++) begin
            if (w_ch_onehot[c] && w_wr) begin
               if (w_addr == NI_H_OP)
                  r_op[c] <= cfg_data_i[0] ? HERMES_RECEIVE : HERMES_SEND;
               if (w_addr == NI_H_SIZE)
                  r_size[c] <= 32'(cfg_data_i[HERMES_FLIT_SIZE-1:0]);
               if (w_addr == NI_H_ADDR)
                  r_addr[c] <= 32'(cfg_data_i[HERMES_FLIT_SIZE-1:0]);
            end
         end
      end
   end

   assign hermes_start_o     = r_start;
   assign hermes_operation_o = r_op;
   assign hermes_size_o      = r_size;
   assign hermes_address_o   = r_addr;

   // BrLite staging record and queue control
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stage   <= '0;
         r_svc_ack <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         if (w_wr) begin
            case (w_addr)
               NI_BR_SERVICE:  r_stage.service  <= cfg_data_i[7:0];
               NI_BR_KSVC:     r_stage.ksvc     <= cfg_data_i[7:0];
               NI_BR_TARGET:   r_stage.target   <= cfg_data_i[15:0];
               NI_BR_PRODUCER: r_stage.producer <= cfg_data_i[15:0];
               NI_BR_PAYLOAD:  r_stage.payload  <= cfg_data_i;
               NI_PENDING_SVC: r_pending        <= cfg_data_i[0];
               default:        ;
            endcase
         end
         r_svc_ack <= w_wr && (w_addr == NI_BR_SVC_POP) && cfg_data_i[0] && !r_svc_ack;
      end
   end

   assign w_push      = w_wr && (w_addr == NI_BR_PUSH) && cfg_data_i[0];
   assign w_pop       = br_ack_i && !w_empty;
   assign w_ovf_set   = w_push && w_full && !w_pop;
   assign w_drain_set = (w_count == CNT_W'(1)) && w_pop && !w_push;

   ni_br_tx_fifo #(
      .DEPTH (BR_TX_DEPTH),
      .T     (br_tx_entry_t)
   ) u_br_tx_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (r_stage),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign br_req_o     = !w_empty;
   assign br_data_o    = w_head;
   assign br_svc_ack_o = r_svc_ack;

   // Sticky event bits: a set in the same cycle as a W1C wins
   assign w_wr_irq = w_wr && (w_addr == NI_IRQ_STATUS);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ovf     <= 1'b0;
         r_drained <= 1'b0;
         r_ch_err  <= 1'b0;
         r_mask    <= '1;
      end else begin
         r_ovf     <= w_ovf_set   || (r_ovf     && !(w_wr_irq && cfg_data_i[N+IRQ_OFS_BR_OVF]));
         r_drained <= w_drain_set || (r_drained && !(w_wr_irq && cfg_data_i[N+IRQ_OFS_TX_DRAINED]));
         r_ch_err  <= w_err_set   || (r_ch_err  && !(w_wr_irq && cfg_data_i[N+IRQ_OFS_CH_ERR]));
         if (w_wr && (w_addr == NI_IRQ_MASK)) r_mask <= cfg_data_i[IRQ_W-1:0];
      end
   end

   always_comb begin
      w_status                         = '0;
      w_status[N-1:0]                  = hermes_receive_avail_i;
      w_status[N+IRQ_OFS_BR_SVC]       = br_svc_rx_i;
      w_status[N+IRQ_OFS_PENDING]      = r_pending;
      w_status[N+IRQ_OFS_BR_OVF]       = r_ovf;
      w_status[N+IRQ_OFS_TX_DRAINED]   = r_drained;
      w_status[N+IRQ_OFS_CH_ERR]       = r_ch_err;
   end

   assign irq_o = |(w_status & r_mask);

`ifdef NI_BR_OVF_CNT_EN
   logic [15:0] r_ovf_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_ovf_cnt <= '0;
      else if (w_wr && (w_addr == NI_BR_OVF_CNT))
         r_ovf_cnt <= '0;
      else if (w_ovf_set && (r_ovf_cnt != 16'hFFFF))
         r_ovf_cnt <= r_ovf_cnt + 16'd1;
   end

   assign w_ovf_cnt = r_ovf_cnt;
`else
   assign w_ovf_cnt = '0;
`endif

   // Read data mux; unmapped and write-only addresses read 0
   always_comb begin
      w_rdata = '0;
      case (w_addr)
         NI_ADDRESS:        w_rdata = 32'(ADDRESS);
         NI_CH_SEL:         w_rdata = 32'(r_ch_sel);
         NI_H_OP: begin
            for (int c = 0; c < int'(N); c++) if (w_ch_onehot[c]) w_rdata = 32'(r_op[c]);
         end
         NI_H_SIZE: begin
            for (int c = 0; c < int'(N); c++) if (w_ch_onehot[c]) w_rdata = r_size[c];
         end
         NI_H_ADDR: begin
            for (int c = 0; c < int'(N); c++) if (w_ch_onehot[c]) w_rdata = r_addr[c];
         end
         NI_BR_TX_LEVEL:    w_rdata = 32'(w_count);
         NI_BR_SVC_HDR:     w_rdata = {br_svc_data_i.service, br_svc_data_i.ksvc,
                                       br_svc_data_i.producer};
         NI_BR_SVC_PAYLOAD: w_rdata = br_svc_data_i.payload;
         NI_PENDING_SVC:    w_rdata = 32'(r_pending);
         NI_IRQ_STATUS:     w_rdata = 32'(w_status);
         NI_IRQ_MASK:       w_rdata = 32'(r_mask);
         NI_BR_OVF_CNT:     w_rdata = 32'(w_ovf_cnt);
         default:           ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     r_rdata <= '0;
      else if (w_rd) r_rdata <= w_rdata;
   end

   assign cfg_data_o = r_rdata;

endmodule

// File: tb/tb_ni_multichannel.sv
// Directed self-checking bench for ni_multichannel (N=2, DEPTH=4).
module tb_ni_multichannel;
   import ni_multichannel_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          cfg_en_i = 1'b0;
   logic          cfg_we_i = 1'b0;
   logic [5:0]    cfg_addr_i = '0;
   logic [31:0]   cfg_data_i = '0;
   logic [31:0]   cfg_data_o;
   logic          irq_o;
   logic [1:0]    hermes_send_active_i = '0;
   logic [1:0]    hermes_receive_avail_i = '0;
   logic [1:0]    hermes_start_o;
   logic [1:0]    hermes_operation_o;
   logic [63:0]   hermes_size_o;
   logic [63:0]   hermes_address_o;
   logic          br_svc_rx_i = 1'b0;
   brlite_svc_t   br_svc_data_i = '0;
   logic          br_svc_ack_o;
   logic          br_req_o;
   logic          br_ack_i = 1'b0;
   brlite_out_t   br_data_o;

   int n_tests = 0;
   int n_fail  = 0;

   ni_multichannel #(
      .N_HERMES_CH(2), .HERMES_FLIT_SIZE(32), .BR_TX_DEPTH(4), .ADDRESS(16'h0)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_en_i(cfg_en_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
      .cfg_data_i(cfg_data_i), .cfg_data_o(cfg_data_o), .irq_o(irq_o),
      .hermes_send_active_i(hermes_send_active_i),
      .hermes_receive_avail_i(hermes_receive_avail_i),
      .hermes_start_o(hermes_start_o), .hermes_operation_o(hermes_operation_o),
      .hermes_size_o(hermes_size_o), .hermes_address_o(hermes_address_o),
      .br_svc_rx_i(br_svc_rx_i), .br_svc_data_i(br_svc_data_i),
      .br_svc_ack_o(br_svc_ack_o), .br_req_o(br_req_o), .br_ack_i(br_ack_i),
      .br_data_o(br_data_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cpu_wr(input ni_reg_t a, input logic [31:0] d);
      cfg_en_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 6'(a); cfg_data_i = d;
      @(posedge clk_i); #1;
      cfg_en_i = 1'b0; cfg_we_i = 1'b0; cfg_data_i = '0;
   endtask

   task automatic cpu_rd(input ni_reg_t a, output logic [31:0] d);
      cfg_en_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = 6'(a);
      @(posedge clk_i); #1;
      cfg_en_i = 1'b0;
      d = cfg_data_o;
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      repeat (3) @(posedge clk_i);
      #1;
      n_tests++; if (br_req_o !== 1'b0 || br_svc_ack_o !== 1'b0 || hermes_start_o !== 2'b00) begin
         n_fail++; $display("FAIL reset_outs: req=%b ack=%b start=%b required 0/0/00", br_req_o, br_svc_ack_o, hermes_start_o); end
      n_tests++; if (hermes_operation_o !== 2'b00 || cfg_data_o !== 32'h0 || irq_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_op: op=%b data=%h irq=%b required 00/0/0", hermes_operation_o, cfg_data_o, irq_o); end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      cpu_rd(NI_IRQ_MASK, rd);
      n_tests++; if (rd !== 32'h7F) begin n_fail++; $display("FAIL reset_mask: got %h required %h", rd, 32'h7F); end
      cpu_rd(NI_BR_TX_LEVEL, rd);
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_level: got %h required 0", rd); end
   endtask

   task automatic test_hermes_start;
      logic [31:0] rd;
      cpu_wr(NI_CH_SEL, 32'd1);
      cpu_wr(NI_H_SIZE, 32'h40);
      cpu_wr(NI_H_ADDR, 32'h1234);
      cpu_wr(NI_H_OP, 32'd1);
      cpu_wr(NI_H_START, 32'd1);
      n_tests++; if (hermes_start_o !== 2'b10) begin n_fail++; $display("FAIL start_pulse: got %b required 10", hermes_start_o); end
      n_tests++; if (hermes_size_o !== {32'h40, 32'h0}) begin n_fail++; $display("FAIL size_out: got %h required %h", hermes_size_o, {32'h40, 32'h0}); end
      n_tests++; if (hermes_address_o !== {32'h1234, 32'h0} || hermes_operation_o !== 2'b10) begin
         n_fail++; $display("FAIL addr_op: addr=%h op=%b required %h/10", hermes_address_o, hermes_operation_o, {32'h1234, 32'h0}); end
      @(posedge clk_i); #1;
      n_tests++; if (hermes_start_o !== 2'b00) begin n_fail++; $display("FAIL start_one_cycle: got %b required 00", hermes_start_o); end
      cpu_rd(NI_H_SIZE, rd);
      n_tests++; if (rd !== 32'h40) begin n_fail++; $display("FAIL size_read: got %h required 40", rd); end
      cpu_wr(NI_CH_SEL, 32'd0);
      cpu_rd(NI_H_SIZE, rd);
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ch0_size_read: got %h required 0", rd); end
      // Out-of-range select: writes ignored, reads 0, no start
      cpu_wr(NI_CH_SEL, 32'd5);
      cpu_wr(NI_H_SIZE, 32'h99);
      cpu_rd(NI_H_SIZE, rd);
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_size_read: got %h required 0", rd); end
      cpu_wr(NI_H_START, 32'd1);
      n_tests++; if (hermes_start_o !== 2'b00 || hermes_size_o !== {32'h40, 32'h0}) begin
         n_fail++; $display("FAIL oor_start: start=%b size=%h required 00/%h", hermes_start_o, hermes_size_o, {32'h40, 32'h0}); end
   endtask

   task automatic test_ch_err;
      logic [31:0] rd;
      cpu_wr(NI_CH_SEL, 32'd0);
      hermes_send_active_i = 2'b01;
      cpu_wr(NI_H_START, 32'd1);
      n_tests++; if (hermes_start_o !== 2'b00 || irq_o !== 1'b1) begin
         n_fail++; $display("FAIL busy_start: start=%b irq=%b required 00/1", hermes_start_o, irq_o); end
      cpu_rd(NI_IRQ_STATUS, rd);
      n_tests++; if (rd !== 32'h40) begin n_fail++; $display("FAIL ch_err_status: got %h required 40", rd); end
      cpu_wr(NI_IRQ_MASK, 32'h3F);
      n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL ch_err_masked: irq=%b required 0", irq_o); end
      hermes_send_active_i = 2'b00;
      cpu_wr(NI_IRQ_MASK, 32'h7F);
      cpu_wr(NI_IRQ_STATUS, 32'h40);
      cpu_rd(NI_IRQ_STATUS, rd);
      n_tests++; if (rd !== 32'h0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL ch_err_w1c: status=%h irq=%b required 0/0", rd, irq_o); end
   endtask

   task automatic test_br_overflow;
      logic [31:0] rd;
      cpu_wr(NI_BR_SERVICE, 32'h3);
      cpu_wr(NI_BR_KSVC, 32'h5);
      cpu_wr(NI_BR_TARGET, 32'h42);
      cpu_wr(NI_BR_PRODUCER, 32'h7);
      for (int i = 0; i < 5; i++) begin
         cpu_wr(NI_BR_PAYLOAD, 32'hA000_0000 + 32'(i));
         cpu_wr(NI_BR_PUSH, 32'd1);
      end
      cpu_rd(NI_BR_TX_LEVEL, rd);
      n_tests++; if (rd !== 32'd4) begin n_fail++; $display("FAIL ovf_level: got %0d required 4", rd); end
      n_tests++; if (br_req_o !== 1'b1 || br_data_o.payload !== 32'hA000_0000 || br_data_o.target !== 16'h42) begin
         n_fail++; $display("FAIL ovf_head: req=%b payload=%h target=%h required 1/a0000000/0042", br_req_o, br_data_o.payload, br_data_o.target); end
      n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL ovf_irq: got %b required 1", irq_o); end
      cpu_rd(NI_IRQ_STATUS, rd);
      n_tests++; if (rd !== 32'h10) begin n_fail++; $display("FAIL ovf_status: got %h required 10", rd); end
      cpu_rd(NI_BR_OVF_CNT, rd);
`ifdef NI_BR_OVF_CNT_EN
      n_tests++; if (rd !== 32'd1) begin n_fail++; $display("FAIL ovf_cnt: got %0d required 1", rd); end
`else
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ovf_cnt: got %0d required 0", rd); end
`endif
      cpu_wr(NI_BR_OVF_CNT, 32'd0);
      cpu_rd(NI_BR_OVF_CNT, rd);
      n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ovf_cnt_clr: got %0d required 0", rd); end
      cpu_wr(NI_IRQ_STATUS, 32'h10);
      n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL ovf_w1c_irq: got %b required 0", irq_o); end
   endtask

   task automatic test_push_pop_full;
      logic [31:0] rd;
      cpu_wr(NI_BR_PAYLOAD, 32'hA000_0005);
      br_ack_i = 1'b1;
      cpu_wr(NI_BR_PUSH, 32'd1);
      br_ack_i = 1'b0;
      n_tests++; if (br_data_o.payload !== 32'hA000_0001) begin
         n_fail++; $display("FAIL pp_head: got %h required a0000001", br_data_o.payload); end
      cpu_rd(NI_BR_TX_LEVEL, rd);
      n_tests++; if (rd !== 32'd4) begin n_fail++; $display("FAIL pp_level: got %0d required 4", rd); end
      cpu_rd(NI_IRQ_STATUS, rd);
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pp_no_ovf: status %h required 0", rd); end
   endtask

   task automatic test_drain;
      logic [31:0] rd;
      logic [31:0] exp_pl [4];
      exp_pl[0] = 32'hA000_0001; exp_pl[1] = 32'hA000_0002;
      exp_pl[2] = 32'hA000_0003; exp_pl[3] = 32'hA000_0005;
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (br_req_o !== 1'b1 || br_data_o.payload !== exp_pl[i]) begin
            n_fail++; $display("FAIL drain_%0d: req=%b payload=%h required 1/%h", i, br_req_o, br_data_o.payload, exp_pl[i]); end
         br_ack_i = 1'b1;
         @(posedge clk_i); #1;
         br_ack_i = 1'b0;
      end
      n_tests++; if (br_req_o !== 1'b0 || irq_o !== 1'b1) begin
         n_fail++; $display("FAIL drain_end: req=%b irq=%b required 0/1", br_req_o, irq_o); end
      cpu_rd(NI_IRQ_STATUS, rd);
      n_tests++; if (rd !== 32'h20) begin n_fail++; $display("FAIL drained_status: got %h required 20", rd); end
      cpu_wr(NI_IRQ_STATUS, 32'h20);
      br_ack_i = 1'b1;
      @(posedge clk_i); #1;
      br_ack_i = 1'b0;
      cpu_rd(NI_BR_TX_LEVEL, rd);
      n_tests++; if (rd !== 32'd0 || irq_o !== 1'b0) begin
         n_fail++; $display("FAIL empty_ack: level=%0d irq=%b required 0/0", rd, irq_o); end
   endtask

   task automatic test_svc;
      logic [31:0] rd;
      br_svc_rx_i = 1'b1;
      br_svc_data_i = '{service: 8'h02, ksvc: 8'h09, producer: 16'h0101, payload: 32'hCAFE_F00D};
      hermes_receive_avail_i = 2'b01;
      cpu_wr(NI_PENDING_SVC, 32'd1);
      cpu_rd(NI_IRQ_STATUS, rd);
      n_tests++; if (rd !== 32'h0D) begin n_fail++; $display("FAIL svc_status: got %h required 0d", rd); end
      cpu_rd(NI_BR_SVC_HDR, rd);
      n_tests++; if (rd !== 32'h0209_0101) begin n_fail++; $display("FAIL svc_hdr: got %h required 02090101", rd); end
      cpu_rd(NI_BR_SVC_PAYLOAD, rd);
      n_tests++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL svc_payload: got %h required cafef00d", rd); end
      cpu_wr(NI_BR_SVC_POP, 32'd1);
      n_tests++; if (br_svc_ack_o !== 1'b1) begin n_fail++; $display("FAIL svc_ack: got %b required 1", br_svc_ack_o); end
      cpu_wr(NI_BR_SVC_POP, 32'd1);
      n_tests++; if (br_svc_ack_o !== 1'b0) begin n_fail++; $display("FAIL svc_ack_b2b: got %b required 0", br_svc_ack_o); end
      br_svc_rx_i = 1'b0;
      hermes_receive_avail_i = 2'b00;
      cpu_wr(NI_PENDING_SVC, 32'd0);
      cpu_rd(NI_IRQ_STATUS, rd);
      n_tests++; if (rd !== 32'h0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL svc_clear: status=%h irq=%b required 0/0", rd, irq_o); end
   endtask

   task automatic test_async_reset;
      cpu_wr(NI_BR_PUSH, 32'd1);
      cpu_wr(NI_CH_SEL, 32'd1);
      cpu_wr(NI_H_START, 32'd1);
      #2 rst_i = 1'b1;
      #1;
      n_tests++; if (br_req_o !== 1'b0 || hermes_start_o !== 2'b00 || hermes_size_o !== 64'h0) begin
         n_fail++; $display("FAIL async_reset: req=%b start=%b size=%h required 0/00/0", br_req_o, hermes_start_o, hermes_size_o); end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_hermes_start();
      test_ch_err();
      test_br_overflow();
      test_push_pop_full();
      test_drain();
      test_svc();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
